aes_inv_key_expand: RTL

//  AES-128 inverse key schedule for the decryption datapath. Accepts the final
//  (round-10) round key and walks the schedule backwards, one round per cycle.

---
 rtl/aes_inv_key_expand_if.sv | 23 ++
 rtl/aes_inv_key_expand.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_expand_if.sv
// Key-in / round-key-out stream bundle for the AES-128 inverse key schedule.
// The slave side is the key-schedule block; the master side feeds keys and consumes round keys.
interface aes_inv_key_expand_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] last_key;
  logic         flush;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output key_valid, last_key, flush, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, done
  );

  modport slave (
    input  key_valid, last_key, flush, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, done
  );
endinterface

// File: rtl/aes_inv_key_expand.sv
// AES-128 inverse key schedule: takes the round-10 key and emits round keys 10..0, one per cycle.
// First beat one cycle after key accept; beats hold while rk_ready is low; flush aborts to idle.
module aes_inv_key_expand #(
  parameter int NR        = 10,
  parameter bit EMIT_LAST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_key_expand_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  state_t       state_q,     state_d;
  logic [127:0] key_reg_q,   key_reg_d;
  logic [3:0]   round_q,     round_d;
  logic [7:0]   rcon_q,      rcon_d;
  logic         rk_valid_q,  rk_valid_d;
  logic         key_ready_q, key_ready_d;
  logic         done_q,      done_d;

  logic [127:0] src;
  logic [7:0]   src_rc;
  logic [31:0]  p0, p1, p2, p3, rot, sub;
  logic [127:0] prev_key;

  // One shared backward step: from the incoming key while idle, from key_reg while emitting.
  always_comb begin
    src    = (state_q == ST_IDLE) ? bus.last_key : key_reg_q;
    src_rc = (state_q == ST_IDLE) ? RCON_LAST    : rcon_q;
    p3     = src[31:0]  ^ src[63:32];
    p2     = src[63:32] ^ src[95:64];
    p1     = src[95:64] ^ src[127:96];
    rot    = {p3[23:0], p3[31:24]};
    sub    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      sub[8*i +: 8] = sbox(rot[8*i +: 8]);
    end
    p0       = src[127:96] ^ sub ^ {src_rc, 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  always_comb begin
    state_d     = state_q;
    key_reg_d   = key_reg_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    rk_valid_d  = rk_valid_q;
    key_ready_d = key_ready_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        key_ready_d = 1'b1;
        rk_valid_d  = 1'b0;
        if (bus.key_valid && key_ready_q && !bus.flush) begin
          state_d     = ST_EMIT;
          key_ready_d = 1'b0;
          rk_valid_d  = 1'b1;
          if (EMIT_LAST) begin
            key_reg_d = bus.last_key;
            round_d   = LAST_ROUND;
            rcon_d    = RCON_LAST;
          end else begin
            key_reg_d = prev_key;
            round_d   = LAST_ROUND - 4'd1;
            rcon_d    = inv_xtime(RCON_LAST);
          end
        end
      end
      ST_EMIT: begin
        if (bus.flush) begin
          state_d     = ST_IDLE;
          rk_valid_d  = 1'b0;
          key_ready_d = 1'b1;
        end else if (bus.rk_ready) begin
          if (round_q == 4'd0) begin
            state_d     = ST_IDLE;
            rk_valid_d  = 1'b0;
            key_ready_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            key_reg_d = prev_key;
            round_d   = round_q - 4'd1;
            rcon_d    = inv_xtime(rcon_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_reg_q   <= 128'h0;
      round_q     <= 4'd0;
      rcon_q      <= RCON_LAST;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_reg_q   <= key_reg_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      rk_valid_q  <= rk_valid_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_data   = key_reg_q;
  assign bus.rk_round  = round_q;
  assign bus.done      = done_q;

endmodule
